bcd_conv_arbiter: RTL and testbench
===================================

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 31, maximum WAIT cycles allowed before abort.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester conversion request, level; held until ack.
REQ-006 bin_in  input  NREQ*14  packed binary operands; slice i = bin_in[14*i+13:14*i], stable while req[i] is high.
REQ-007 ack  output  NREQ  one-hot, one-cycle pulse; request accepted and operand captured.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 resp_valid  output  NREQ  one-hot, one-cycle pulse; result for that requester is on the bcd outputs.
REQ-010 bcd3, bcd2, bcd1, bcd0  output  4 each  BCD result (thousands..units), held until the next response.
REQ-011 resp_ovf  output  1  operand was clamped; valid with resp_valid, held.
REQ-012 resp_err  output  1  conversion timed out; valid with resp_valid, held.

Function
REQ-013 The block shall share one bin2bcd converter (ports start, bin[13:0], ready, done_tick, bcd3..bcd0) among NREQ requesters.
REQ-014 The FSM shall have states IDLE, ISSUE, WAIT, RESP, with transitions: IDLE->ISSUE on any req bit; ISSUE->WAIT when converter ready=1; WAIT->RESP on done_tick or timeout; RESP->IDLE unconditionally.
REQ-015 The grant shall be round-robin: search starts at last_grant+1 modulo NREQ; after reset last_grant=NREQ-1, so req[0] has priority first.
REQ-016 On the IDLE->ISSUE edge the block shall latch the grant index and operand, and ack[grant] shall be high for exactly the following cycle.
REQ-017 The latched operand shall be clamped: values above 9999 convert as 9999 with resp_ovf=1; otherwise resp_ovf=0.
REQ-018 start shall be asserted combinationally only in ISSUE while ready=1, never in any other state.
REQ-019 In WAIT a cycle counter shall run; if done_tick has not arrived after TIMEOUT cycles, the FSM shall go to RESP with resp_err=1 and bcd3..bcd0 = 0.
REQ-020 On done_tick the converter bcd outputs shall be registered into bcd3..bcd0, with resp_err=0.
REQ-021 In RESP, resp_valid[grant] shall be high for one cycle and last_grant shall update to grant.
REQ-022 Latency: resp_valid shall rise exactly 16 cycles after the ack cycle on a normal conversion; back-to-back grants shall be 18 cycles apart.
REQ-023 A req dropped before its ack shall be ignored; a req dropped after ack shall not affect the conversion in flight.
REQ-024 A req arriving while busy shall wait; only IDLE samples req.

Reset
REQ-025 While reset_n=0: state=IDLE, ack=0, resp_valid=0, busy=0, bcd outputs=0, resp_ovf=0, resp_err=0, counters=0, last_grant=NREQ-1.
REQ-026 Reset mid-conversion shall abort without a response; the converter shares reset_n.

Structure
REQ-027 A shared package shall hold the state encoding, BIN_W=14, BCD_MAX=9999 and the default TIMEOUT.
REQ-028 The only sub-module shall be one bin2bcd instance; the arbiter, clamp and timeout logic are local.

Verification
REQ-029 Single request: req[0]=1 with bin 1234 -> ack[0] one cycle, resp_valid[0] 16 cycles later, bcd=1,2,3,4, ovf=0, err=0.
REQ-030 Clamp: req[2] with bin 16383 -> bcd=9,9,9,9, resp_ovf=1.
REQ-031 Fairness: all four req held high -> grants in order 0,1,2,3,0, 18 cycles apart.
REQ-032 Withdrawal: req[1] pulsed for one cycle while busy -> no ack[1], no resp_valid[1].
REQ-033 Timeout: stub converter that never asserts done_tick -> resp_valid after TIMEOUT+ cycles, resp_err=1, bcd=0.
REQ-034 Reset in WAIT: reset_n low for 2 cycles -> all outputs 0; next req[3] is serviced with correct BCD.

Source files
------------

// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types, constants and helpers for the BCD conversion arbiter.
package bcd_conv_arbiter_pkg;
  localparam int BIN_W       = 14;
  localparam int BCD_MAX     = 9999;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_t;

  // Double-dabble correction: digits >= 5 get +3 before the next shift.
  function automatic logic [15:0] bcd_adj(input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = (d[4*k +: 4] >= 4'd5) ? d[4*k +: 4] + 4'd3 : d[4*k +: 4];
    return r;
  endfunction

  // Saturate an operand to the largest four-digit value.
  function automatic logic [BIN_W-1:0] clamp_op(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(BCD_MAX)) ? BIN_W'(BCD_MAX) : v;
  endfunction
endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the arbiter: requests, operands, acks and results.
interface bcd_conv_arbiter_if import bcd_conv_arbiter_pkg::*; #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] bin_in;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [NREQ-1:0]       resp_valid;
  logic [3:0]            bcd3, bcd2, bcd1, bcd0;
  logic                  resp_ovf;
  logic                  resp_err;

  modport master (
    output req, bin_in,
    input  ack, busy, resp_valid, bcd3, bcd2, bcd1, bcd0, resp_ovf, resp_err
  );

  modport slave (
    input  req, bin_in,
    output ack, busy, resp_valid, bcd3, bcd2, bcd1, bcd0, resp_ovf, resp_err
  );
endinterface

// File: rtl/bcd_conv_arbiter_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// start is taken only while ready; done_tick pulses with the result valid.
module bcd_conv_arbiter_bin2bcd import bcd_conv_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);
  logic             run;
  logic [3:0]       cnt;
  logic [BIN_W-1:0] sh;
  logic [15:0]      acc;
  logic [15:0]      acc_adj;

  assign acc_adj = bcd_adj(acc);
  assign ready   = !run;
  assign {bcd3, bcd2, bcd1, bcd0} = acc;

  // Load on start, then shift one operand bit into the BCD digits per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run       <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      acc       <= '0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      if (start && !run) begin
        run <= 1'b1;
        cnt <= '0;
        sh  <= bin;
        acc <= '0;
      end else if (run) begin
        {acc, sh} <= {acc_adj, sh} << 1;
        cnt       <= cnt + 4'd1;
        if (cnt == 4'(BIN_W-1)) begin
          run       <= 1'b0;
          done_tick <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2bcd converter among NREQ requesters.
// Operands are clamped to 9999 on capture; a stuck conversion is aborted
// after TIMEOUT cycles in WAIT and answered with an error and zero digits.
module bcd_conv_arbiter import bcd_conv_arbiter_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               reset_n,
  bcd_conv_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [GW-1:0]    last_grant, grant, pick;
  logic             any_req;
  logic [BIN_W-1:0] pick_bin, op;
  logic             op_ovf;
  logic [CW-1:0]    wait_cnt;
  logic             timed_out;
  logic [NREQ-1:0]  ack_q;
  bcd_t             res;
  logic             res_ovf, res_err;
  logic             conv_start, conv_ready, conv_done;
  logic [3:0]       cb3, cb2, cb1, cb0;

  // Round-robin pick: first requester after last_grant, wrapping.
  always_comb begin
    any_req = |bus.req;
    pick    = last_grant;
    for (int i = NREQ; i >= 1; i--)
      if (bus.req[(int'(last_grant) + i) % NREQ])
        pick = GW'((int'(last_grant) + i) % NREQ);
  end

  assign pick_bin   = bus.bin_in[BIN_W*int'(pick) +: BIN_W];
  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1)) && !conv_done;
  assign conv_start = (state == ISSUE) && conv_ready;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: if (conv_ready) state_nxt = WAIT;
      WAIT:  if (conv_done || timed_out) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant capture, timeout counter, result registers and grant history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= '0;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      op         <= '0;
      op_ovf     <= 1'b0;
      wait_cnt   <= '0;
      res        <= '0;
      res_ovf    <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      ack_q <= '0;
      if (state == IDLE && any_req) begin
        ack_q  <= NREQ'(1) << pick;
        grant  <= pick;
        op     <= clamp_op(pick_bin);
        op_ovf <= pick_bin > BIN_W'(BCD_MAX);
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == WAIT) begin
        if (conv_done) begin
          res     <= {cb3, cb2, cb1, cb0};
          res_ovf <= op_ovf;
          res_err <= 1'b0;
        end else if (timed_out) begin
          res     <= '0;
          res_ovf <= op_ovf;
          res_err <= 1'b1;
        end
      end
      if (state == RESP) last_grant <= grant;
    end
  end

  bcd_conv_arbiter_bin2bcd u_conv (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (conv_start),
    .bin       (op),
    .ready     (conv_ready),
    .done_tick (conv_done),
    .bcd3      (cb3),
    .bcd2      (cb2),
    .bcd1      (cb1),
    .bcd0      (cb0)
  );

  assign bus.ack        = ack_q;
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == RESP) ? (NREQ'(1) << grant) : '0;
  assign bus.bcd3       = res.d3;
  assign bus.bcd2       = res.d2;
  assign bus.bcd1       = res.d1;
  assign bus.bcd0       = res.d0;
  assign bus.resp_ovf   = res_ovf;
  assign bus.resp_err   = res_err;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random operands,
// checked against a decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;
  localparam int N    = 4;
  localparam int TO_B = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.NREQ(N)) bifA ();
  bcd_conv_arbiter_if #(.NREQ(N)) bifB ();

  bcd_conv_arbiter #(.NREQ(N)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(bifA.slave)
  );
  bcd_conv_arbiter #(.NREQ(N), .TIMEOUT(TO_B)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(bifB.slave)
  );

  typedef struct { int cyc; logic [N-1:0] vec; } ack_ev_t;
  typedef struct { int cyc; logic [N-1:0] vec; logic [15:0] bcd; logic ovf; logic err; } rsp_ev_t;

  ack_ev_t ackq[$];
  rsp_ev_t rspq[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log for dutA, sampled mid-cycle.
  always @(negedge clk) begin
    if (bifA.ack != '0) ackq.push_back('{cyc, bifA.ack});
    if (bifA.resp_valid != '0)
      rspq.push_back('{cyc, bifA.resp_valid,
                       {bifA.bcd3, bifA.bcd2, bifA.bcd1, bifA.bcd0},
                       bifA.resp_ovf, bifA.resp_err});
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (bifA.busy !== 1'b0 && t < 60) begin tick(1); t++; end
    chk({tag, " idle"}, 32'(bifA.busy), 32'd0);
  endtask

  // One request on dutA, full check of ack, latency and result.
  task automatic run_one(input int who, input int v, input string tag);
    int na, nr, t;
    logic [N-1:0] oh;
    na = ackq.size();
    nr = rspq.size();
    oh = N'(1) << who;
    bifA.bin_in[14*who +: 14] = 14'(v);
    bifA.req[who] = 1'b1;
    t = 0;
    while (ackq.size() == na && t < 20) begin tick(1); t++; end
    bifA.req[who] = 1'b0;
    t = 0;
    while (rspq.size() == nr && t < 60) begin tick(1); t++; end
    tick(1);
    chk({tag, " ack_count"}, 32'(ackq.size() - na), 32'd1);
    chk({tag, " rsp_count"}, 32'(rspq.size() - nr), 32'd1);
    if (ackq.size() > na && rspq.size() > nr) begin
      chk({tag, " ack_vec"}, 32'(ackq[na].vec), 32'(oh));
      chk({tag, " rsp_vec"}, 32'(rspq[nr].vec), 32'(oh));
      chk({tag, " latency"}, 32'(rspq[nr].cyc - ackq[na].cyc), 32'd16);
      chk({tag, " bcd"}, 32'(rspq[nr].bcd), 32'(model_bcd(v)));
      chk({tag, " ovf"}, 32'(rspq[nr].ovf), 32'(v > 9999));
      chk({tag, " err"}, 32'(rspq[nr].err), 32'd0);
    end
    wait_idle(tag);
  endtask

  initial begin
    int na, nr, t, n1a, n1r, lat, acb;
    int vals[N];

    bifA.req = '0; bifA.bin_in = '0;
    bifB.req = '0; bifB.bin_in = '0;

    // Reset state
    tick(3);
    chk("rst ack", 32'(bifA.ack), 32'd0);
    chk("rst busy", 32'(bifA.busy), 32'd0);
    chk("rst resp_valid", 32'(bifA.resp_valid), 32'd0);
    chk("rst bcd", 32'({bifA.bcd3, bifA.bcd2, bifA.bcd1, bifA.bcd0}), 32'd0);
    chk("rst ovf_err", 32'({bifA.resp_ovf, bifA.resp_err}), 32'd0);
    chk("rstB busy", 32'(bifB.busy), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single request and clamp
    run_one(0, 1234, "single");
    run_one(2, 16383, "clamp");
    run_one(1, 9999, "max");
    run_one(3, 10000, "clamp_edge");
    run_one(0, 0, "zero");

    // Random operands and requesters
    for (int k = 0; k < 6; k++) begin
      int who, v;
      who = $urandom_range(0, N - 1);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      run_one(who, v, "random");
    end

    // Fairness from a fresh reset: all requesters held high
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(1);
    na = ackq.size();
    nr = rspq.size();
    for (int k = 0; k < N; k++) begin
      vals[k] = $urandom_range(0, 16383);
      bifA.bin_in[14*k +: 14] = 14'(vals[k]);
    end
    bifA.req = '1;
    t = 0;
    while (ackq.size() < na + 5 && t < 200) begin tick(1); t++; end
    bifA.req = '0;
    t = 0;
    while (rspq.size() < nr + 5 && t < 60) begin tick(1); t++; end
    tick(1);
    chk("fair ack_count", 32'(ackq.size() - na), 32'd5);
    chk("fair rsp_count", 32'(rspq.size() - nr), 32'd5);
    if (ackq.size() >= na + 5 && rspq.size() >= nr + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("fair ack_order", 32'(ackq[na+k].vec), 32'(N'(1) << (k % N)));
        chk("fair rsp_order", 32'(rspq[nr+k].vec), 32'(N'(1) << (k % N)));
        chk("fair bcd", 32'(rspq[nr+k].bcd), 32'(model_bcd(vals[k % N])));
        chk("fair latency", 32'(rspq[nr+k].cyc - ackq[na+k].cyc), 32'd16);
        if (k > 0)
          chk("fair spacing", 32'(ackq[na+k].cyc - ackq[na+k-1].cyc), 32'd18);
      end
    end
    wait_idle("fair");

    // Withdrawal: req[1] pulsed for one cycle while busy
    na = ackq.size();
    nr = rspq.size();
    bifA.bin_in[0 +: 14] = 14'd4321;
    bifA.req[0] = 1'b1;
    t = 0;
    while (ackq.size() == na && t < 20) begin tick(1); t++; end
    bifA.req[0] = 1'b0;
    tick(5);
    bifA.bin_in[14 +: 14] = 14'd777;
    bifA.req[1] = 1'b1;
    tick(1);
    bifA.req[1] = 1'b0;
    tick(40);
    n1a = 0; n1r = 0;
    for (int k = na; k < ackq.size(); k++) if (ackq[k].vec[1]) n1a++;
    for (int k = nr; k < rspq.size(); k++) if (rspq[k].vec[1]) n1r++;
    chk("withdraw ack1", 32'(n1a), 32'd0);
    chk("withdraw rsp1", 32'(n1r), 32'd0);
    chk("withdraw rsp_count", 32'(rspq.size() - nr), 32'd1);
    if (rspq.size() > nr)
      chk("withdraw bcd", 32'(rspq[nr].bcd), 32'(model_bcd(4321)));

    // Reset during WAIT aborts without a response
    na = ackq.size();
    nr = rspq.size();
    bifA.bin_in[0 +: 14] = 14'd2468;
    bifA.req[0] = 1'b1;
    t = 0;
    while (ackq.size() == na && t < 20) begin tick(1); t++; end
    bifA.req[0] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    chk("rstwait busy", 32'(bifA.busy), 32'd0);
    chk("rstwait ack_rv", 32'({bifA.ack, bifA.resp_valid}), 32'd0);
    chk("rstwait bcd", 32'({bifA.bcd3, bifA.bcd2, bifA.bcd1, bifA.bcd0}), 32'd0);
    chk("rstwait ovf_err", 32'({bifA.resp_ovf, bifA.resp_err}), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(25);
    chk("rstwait no_rsp", 32'(rspq.size() - nr), 32'd0);
    run_one(3, int'($urandom_range(0, 9999)), "after_rst");

    // Timeout: dutB gives up long before its converter finishes
    bifB.bin_in[14 +: 14] = 14'd500;
    bifB.req[1] = 1'b1;
    t = 0;
    while (bifB.ack == '0 && t < 20) begin tick(1); t++; end
    acb = cyc;
    chk("timeout ack", 32'(bifB.ack), 32'b0010);
    bifB.req[1] = 1'b0;
    t = 0;
    while (bifB.resp_valid == '0 && t < 60) begin tick(1); t++; end
    lat = cyc - acb;
    chk("timeout rsp_vec", 32'(bifB.resp_valid), 32'b0010);
    chk("timeout err", 32'(bifB.resp_err), 32'd1);
    chk("timeout bcd", 32'({bifB.bcd3, bifB.bcd2, bifB.bcd1, bifB.bcd0}), 32'd0);
    chk("timeout ovf", 32'(bifB.resp_ovf), 32'd0);
    chk("timeout latency", 32'(lat > TO_B && lat <= TO_B + 2), 32'd1);
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
